// File: rtl/pet_memmap_ctrl.sv
// pet_memmap_ctrl: PET memory map (base RAM, mirrored VRAM, ROM image, I/O window) plus a DMA port sharing RAM/ROM.
// Latency: CPU read data 1 clk after its ce_1m cycle; video/chargen 1 clk; dma_ack 2 clk after the request is taken.
// Backpressure: DMA waits for a cycle without ce_1m, video/chargen never stall; macro PET_EXPRAM_EN adds banked expansion RAM.
module pet_memmap_ctrl #(
    parameter int         RAM_AW     = 15,
    parameter int         VRAM_AW    = 10,
    parameter logic [7:0] IO_PAGE    = 8'hE8,
    parameter logic [7:0] UNMAP_DATA = 8'h55
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               ce_1m_i,
    input  logic [15:0]        addr_i,
    input  logic [7:0]         data_in_i,
    input  logic               we_i,
    output logic [7:0]         data_out_o,
    output logic               io_sel_o,
    input  logic [7:0]         io_data_i,
    input  logic [VRAM_AW-1:0] vid_addr_i,
    output logic [7:0]         vid_data_o,
    input  logic [10:0]        char_addr_i,
    output logic [7:0]         char_data_o,
    input  logic               dma_req_i,
    input  logic               dma_we_i,
    input  logic [15:0]        dma_addr_i,
    input  logic [7:0]         dma_din_i,
    output logic [7:0]         dma_dout_o,
    output logic               dma_ack_o
);

    localparam int RAM_BYTES  = 1 << RAM_AW;
    localparam int VRAM_BYTES = 1 << VRAM_AW;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
    typedef enum logic [2:0] {SRC_RAM, SRC_UNMAP, SRC_VRAM, SRC_ROM, SRC_IO, SRC_EXP} src_e;

    // Memory arrays; contents are not reset (the ROM image is loaded through the DMA port).
    logic [7:0] ram_q  [RAM_BYTES];
    logic [7:0] vram_q [VRAM_BYTES];
    logic [7:0] rom_q  [32768];

    state_e     state_q, state_d;
    src_e       cpu_src;
    logic [7:0] data_out_q;
    logic [7:0] dma_dout_q;
    logic [7:0] vid_data_q;
    logic [7:0] char_data_q;
    logic       cpu_wr;
    logic       cpu_ram_pop;
    logic       dma_ram_pop;
    logic       dma_wr;
    logic       vram_win;
    logic       io_win;

    assign cpu_wr      = ce_1m_i && we_i && !reset_i;
    assign cpu_ram_pop = int'(addr_i[14:0]) < RAM_BYTES;
    assign dma_ram_pop = int'(dma_addr_i[14:0]) < RAM_BYTES;
    // The FSM only reaches ACCESS on a non-ce cycle; reset during ACCESS drops the write.
    assign dma_wr      = (state_q == ST_ACCESS) && dma_we_i && !reset_i;
    assign vram_win    = addr_i[15:12] == 4'h8;
    assign io_win      = addr_i[15:11] == 5'b11101;
    assign io_sel_o    = addr_i[15:8] == IO_PAGE;

`ifdef PET_EXPRAM_EN
    logic [7:0]  exp_q [65536];
    logic [7:0]  ctrl_q;
    logic [15:0] exp_idx;
    logic        exp_wp;

    // $8000-$BFFF selects bank 0/2, $C000-$FFFF selects bank 1/3.
    assign exp_idx = {addr_i[14] ? (ctrl_q[3] ? 2'd3 : 2'd1) : (ctrl_q[2] ? 2'd2 : 2'd0), addr_i[13:0]};
    assign exp_wp  = addr_i[14] ? ctrl_q[1] : ctrl_q[0];

    // Control register: written by any CPU store to $FFF0, regardless of mapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q <= 8'h00;
        end else if (cpu_wr && addr_i == 16'hFFF0) begin
            ctrl_q <= data_in_i;
        end
    end

    // Expansion RAM write port; write-protect bits silently drop stores.
    always_ff @(posedge clk_i) begin
        if (cpu_wr && cpu_src == SRC_EXP && !exp_wp) begin
            exp_q[exp_idx] <= data_in_i;
        end
    end
`endif

    // CPU address decode into a read/write source.
    always_comb begin
        cpu_src = SRC_ROM;
        if (!addr_i[15]) begin
            cpu_src = cpu_ram_pop ? SRC_RAM : SRC_UNMAP;
        end else if (vram_win) begin
            cpu_src = SRC_VRAM;
        end else if (io_win) begin
            cpu_src = SRC_IO;
        end
`ifdef PET_EXPRAM_EN
        if (addr_i[15] && ctrl_q[7]) begin
            cpu_src = SRC_EXP;
            if (ctrl_q[5] && vram_win) begin
                cpu_src = SRC_VRAM;
            end
            if (ctrl_q[6] && io_win) begin
                cpu_src = SRC_IO;
            end
        end
`endif
    end

    // Base RAM write port shared by CPU (ce cycles) and DMA (ACCESS cycles).
    always_ff @(posedge clk_i) begin
        if (cpu_wr && cpu_src == SRC_RAM) begin
            ram_q[addr_i[RAM_AW-1:0]] <= data_in_i;
        end
        if (dma_wr && !dma_addr_i[15] && dma_ram_pop) begin
            ram_q[dma_addr_i[RAM_AW-1:0]] <= dma_din_i;
        end
    end

    // Video RAM write port; only the CPU writes it, mirrored across $8000-$8FFF.
    always_ff @(posedge clk_i) begin
        if (cpu_wr && cpu_src == SRC_VRAM) begin
            vram_q[addr_i[VRAM_AW-1:0]] <= data_in_i;
        end
    end

    // ROM image write port; only DMA can load it, CPU stores are ignored.
    always_ff @(posedge clk_i) begin
        if (dma_wr && dma_addr_i[15]) begin
            rom_q[dma_addr_i[14:0]] <= dma_din_i;
        end
    end

    // CPU read data register, updated only on ce cycles and held in between.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_out_q <= 8'h00;
        end else if (ce_1m_i) begin
            case (cpu_src)
                SRC_RAM:   data_out_q <= ram_q[addr_i[RAM_AW-1:0]];
                SRC_UNMAP: data_out_q <= UNMAP_DATA;
                SRC_VRAM:  data_out_q <= vram_q[addr_i[VRAM_AW-1:0]];
                SRC_IO:    data_out_q <= io_data_i;
`ifdef PET_EXPRAM_EN
                SRC_EXP:   data_out_q <= exp_q[exp_idx];
`endif
                default:   data_out_q <= rom_q[addr_i[14:0]];
            endcase
        end
    end

    // Independent video and chargen read ports (chargen lives at $E800 of the ROM image).
    always_ff @(posedge clk_i) begin
        vid_data_q  <= vram_q[vid_addr_i];
        char_data_q <= rom_q[{4'b1101, char_addr_i}];
    end

    // DMA read data captured during ACCESS, presented alongside the ack.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dma_dout_q <= 8'h00;
        end else if (state_q == ST_ACCESS && !dma_we_i) begin
            if (dma_addr_i[15]) begin
                dma_dout_q <= rom_q[dma_addr_i[14:0]];
            end else if (dma_ram_pop) begin
                dma_dout_q <= ram_q[dma_addr_i[RAM_AW-1:0]];
            end else begin
                dma_dout_q <= UNMAP_DATA;
            end
        end
    end

    // DMA FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DMA FSM next state and ack: the CPU owns every ce_1m cycle.
    always_comb begin
        state_d   = state_q;
        dma_ack_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_req_i && !ce_1m_i) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                dma_ack_o = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_out_o  = data_out_q;
    assign dma_dout_o  = dma_dout_q;
    assign vid_data_o  = vid_data_q;
    assign char_data_o = char_data_q;

endmodule

// File: tb/tb_pet_memmap_ctrl.sv
// Testbench for pet_memmap_ctrl with an 8KB base RAM: directed steps then randomized traffic.
// Expected values come from an address-space model built from assoc arrays.
module tb_pet_memmap_ctrl;

    localparam int RAM_AW_T   = 13;
    localparam int VRAM_AW_T  = 10;
    localparam int RAM_BYTES  = 1 << RAM_AW_T;
    localparam int VRAM_BYTES = 1 << VRAM_AW_T;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  din = '0;
    logic        we = 1'b0;
    logic [7:0]  dout;
    logic        io_sel;
    logic [7:0]  io_data = '0;
    logic [9:0]  vid_addr = '0;
    logic [7:0]  vid_data;
    logic [10:0] char_addr = '0;
    logic [7:0]  char_data;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_din = '0;
    logic [7:0]  dma_dout;
    logic        dma_ack;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram_m  [int];
    logic [7:0] vram_m [int];
    logic [7:0] rom_m  [int];
    int known[$];
    int vidx_q[$];
    int cidx_q[$];

    always #5 clk = ~clk;

    pet_memmap_ctrl #(.RAM_AW(RAM_AW_T), .VRAM_AW(VRAM_AW_T), .IO_PAGE(8'hE8), .UNMAP_DATA(8'h55)) dut (
        .clk_i(clk), .reset_i(reset), .ce_1m_i(ce), .addr_i(addr), .data_in_i(din), .we_i(we),
        .data_out_o(dout), .io_sel_o(io_sel), .io_data_i(io_data),
        .vid_addr_i(vid_addr), .vid_data_o(vid_data), .char_addr_i(char_addr), .char_data_o(char_data),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_din_i(dma_din),
        .dma_dout_o(dma_dout), .dma_ack_o(dma_ack)
    );

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model of the base memory map.
    task automatic mdl_cpu_write(input int a, input logic [7:0] d);
        if (a < 'h8000) begin
            if (a < RAM_BYTES) begin ram_m[a] = d; known.push_back(a); end
        end else if (a < 'h9000) begin
            vram_m[a % VRAM_BYTES] = d;
            vidx_q.push_back(a % VRAM_BYTES);
            known.push_back(a);
        end
    endtask

    task automatic mdl_dma_write(input int a, input logic [7:0] d);
        if (a < 'h8000) begin
            if (a < RAM_BYTES) begin ram_m[a] = d; known.push_back(a); end
        end else begin
            rom_m[a - 'h8000] = d;
            known.push_back(a);
            if (a >= 'hE800 && a < 'hF000) cidx_q.push_back(a - 'hE800);
        end
    endtask

    function automatic bit mdl_cpu_read(input int a, input logic [7:0] io, output logic [7:0] v);
        v = 8'h00;
        if (a < 'h8000) begin
            if (a >= RAM_BYTES) begin v = 8'h55; return 1'b1; end
            if (!ram_m.exists(a)) return 1'b0;
            v = ram_m[a];
            return 1'b1;
        end
        if (a < 'h9000) begin
            if (!vram_m.exists(a % VRAM_BYTES)) return 1'b0;
            v = vram_m[a % VRAM_BYTES];
            return 1'b1;
        end
        if (a >= 'hE800 && a < 'hF000) begin v = io; return 1'b1; end
        if (!rom_m.exists(a - 'h8000)) return 1'b0;
        v = rom_m[a - 'h8000];
        return 1'b1;
    endfunction

    function automatic bit mdl_dma_read(input int a, output logic [7:0] v);
        v = 8'h00;
        if (a < 'h8000) begin
            if (a >= RAM_BYTES) begin v = 8'h55; return 1'b1; end
            if (!ram_m.exists(a)) return 1'b0;
            v = ram_m[a];
            return 1'b1;
        end
        if (!rom_m.exists(a - 'h8000)) return 1'b0;
        v = rom_m[a - 'h8000];
        return 1'b1;
    endfunction

    // One CPU cycle (ce pulse) followed by an idle clk; returns data_out after the ce edge.
    task automatic cpu_access(input logic [15:0] a, input logic w, input logic [7:0] d,
                              input bit upd, output logic [7:0] rd);
        ce = 1'b1; addr = a; we = w; din = d;
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
        rd = dout;
        if (w && upd) mdl_cpu_write(int'(a), d);
        @(posedge clk); #1;
    endtask

    // Issue one DMA transfer on non-ce cycles; lat counts clk edges until ack (0 = never).
    task automatic dma_xfer(input logic w, input logic [15:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output int lat);
        dma_req = 1'b1; dma_we = w; dma_addr = a; dma_din = d;
        lat = 0; rd = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (dma_ack) begin lat = i; rd = dma_dout; break; end
        end
        dma_req = 1'b0;
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL dma_timeout addr=%h got=no_ack expected=ack", a);
        end else if (w) begin
            mdl_dma_write(int'(a), d);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] ev;
        int         lat;
        int         a;
        int         acks;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check8("rst_data_out", dout, 8'h00);
        check8("rst_dma_ack", {7'd0, dma_ack}, 8'h00);
        check8("rst_dma_dout", dma_dout, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        // ROM image byte read back one clk after ce, and held afterwards.
        dma_xfer(1'b1, 16'hC000, 8'hA7, rd, lat);
        check8("rom_load_lat", 8'(lat), 8'd2);
        cpu_access(16'hC000, 1'b0, 8'h00, 1'b1, rd);
        check8("rom_read_C000", rd, 8'hA7);
        check8("rom_read_held", dout, 8'hA7);

        // Populated RAM boundary with 8KB.
        cpu_access(16'h2000, 1'b1, 8'h3C, 1'b1, rd);
        cpu_access(16'h2000, 1'b0, 8'h00, 1'b1, rd);
        check8("unmap_2000", rd, 8'h55);
        cpu_access(16'h1FFF, 1'b1, 8'h3C, 1'b1, rd);
        cpu_access(16'h1FFF, 1'b0, 8'h00, 1'b1, rd);
        check8("ram_1FFF", rd, 8'h3C);
        dma_xfer(1'b0, 16'h2000, 8'h00, rd, lat);
        check8("dma_unmap_2000", rd, 8'h55);

        // DMA write then CPU read.
        dma_xfer(1'b1, 16'h0400, 8'hA5, rd, lat);
        check8("dma_wr_lat", 8'(lat), 8'd2);
        cpu_access(16'h0400, 1'b0, 8'h00, 1'b1, rd);
        check8("cpu_after_dma", rd, 8'hA5);

        // DMA request on a ce cycle: CPU write lands first, DMA read sees it.
        ce = 1'b1; addr = 16'h0400; we = 1'b1; din = 8'h11;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0400;
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
        mdl_cpu_write(32'h0400, 8'h11);
        check8("defer_no_ack", {7'd0, dma_ack}, 8'h00);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (dma_ack) begin lat = i; rd = dma_dout; break; end
        end
        dma_req = 1'b0;
        check8("defer_lat", 8'(lat), 8'd2);
        check8("defer_dout", rd, 8'h11);
        @(posedge clk); #1;

        // Reset during ACCESS of a DMA write.
        cpu_access(16'h0500, 1'b1, 8'h42, 1'b1, rd);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0500; dma_din = 8'h99;
        @(posedge clk); #1;
        reset = 1'b1; dma_req = 1'b0;
        acks = 0;
        @(posedge clk); #1;
        if (dma_ack) acks++;
        check8("rst_mid_data_out", dout, 8'h00);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (dma_ack) acks++;
        end
        check8("rst_mid_no_ack", 8'(acks), 8'd0);
        cpu_access(16'h0500, 1'b0, 8'h00, 1'b1, rd);
        check8("rst_mid_unchanged", rd, 8'h42);

        // VRAM mirror, video port, chargen port, I/O window.
        cpu_access(16'h8005, 1'b1, 8'h5A, 1'b1, rd);
        cpu_access(16'h8405, 1'b0, 8'h00, 1'b1, rd);
        check8("vram_mirror", rd, 8'h5A);
        vid_addr = 10'd5;
        @(posedge clk); #1;
        check8("vid_port", vid_data, 8'h5A);
        dma_xfer(1'b1, 16'hE923, 8'hC3, rd, lat);
        char_addr = 11'h123;
        @(posedge clk); #1;
        check8("char_port", char_data, 8'hC3);
        io_data = 8'h9B;
        cpu_access(16'hE810, 1'b0, 8'h00, 1'b1, rd);
        check8("io_read", rd, 8'h9B);
        addr = 16'hE8F0; #1;
        check8("io_sel_hit", {7'd0, io_sel}, 8'h01);
        addr = 16'hE900; #1;
        check8("io_sel_miss", {7'd0, io_sel}, 8'h00);
        cpu_access(16'hC000, 1'b1, 8'hEE, 1'b1, rd);
        cpu_access(16'hC000, 1'b0, 8'h00, 1'b1, rd);
        check8("rom_write_ignored", rd, 8'hA7);

`ifdef PET_EXPRAM_EN
        // Banked expansion RAM hides VRAM until ctrl is cleared.
        cpu_access(16'h8100, 1'b1, 8'h21, 1'b1, rd);
        cpu_access(16'hFFF0, 1'b1, 8'h84, 1'b0, rd);
        cpu_access(16'h8100, 1'b1, 8'h77, 1'b0, rd);
        cpu_access(16'h8100, 1'b0, 8'h00, 1'b0, rd);
        check8("exp_read", rd, 8'h77);
        cpu_access(16'hFFF0, 1'b1, 8'h00, 1'b0, rd);
        cpu_access(16'h8100, 1'b0, 8'h00, 1'b0, rd);
        check8("exp_vram_unchanged", rd, 8'h21);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0: begin
                    a = int'($urandom_range(0, 16'hFFEF));
                    cpu_access(16'(a), 1'b1, 8'($urandom), 1'b1, rd);
                end
                1: begin
                    if (known.size() > 0 && $urandom_range(0, 2) != 0)
                        a = known[$urandom_range(0, known.size() - 1)];
                    else
                        a = int'($urandom_range(0, 16'hFFFF));
                    io_data = 8'($urandom);
                    cpu_access(16'(a), 1'b0, 8'h00, 1'b1, rd);
                    if (mdl_cpu_read(a, io_data, ev)) check8("rnd_cpu_read", rd, ev);
                end
                2: begin
                    if ($urandom_range(0, 2) == 0)
                        a = 'hE800 + int'($urandom_range(0, 2047));
                    else
                        a = int'($urandom_range(0, 16'hFFFF));
                    dma_xfer(1'b1, 16'(a), 8'($urandom), rd, lat);
                end
                3: begin
                    if (known.size() > 0 && $urandom_range(0, 2) != 0)
                        a = known[$urandom_range(0, known.size() - 1)];
                    else
                        a = int'($urandom_range(0, 16'hFFFF));
                    dma_xfer(1'b0, 16'(a), 8'h00, rd, lat);
                    if (mdl_dma_read(a, ev)) check8("rnd_dma_read", rd, ev);
                end
                4: begin
                    if (vidx_q.size() > 0) begin
                        a = vidx_q[$urandom_range(0, vidx_q.size() - 1)];
                        vid_addr = 10'(a);
                        @(posedge clk); #1;
                        check8("rnd_vid", vid_data, vram_m[a]);
                    end
                end
                default: begin
                    if (cidx_q.size() > 0) begin
                        a = cidx_q[$urandom_range(0, cidx_q.size() - 1)];
                        char_addr = 11'(a);
                        @(posedge clk); #1;
                        check8("rnd_char", char_data, rom_m['h6800 + a]);
                    end
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
